// File: rtl/bp_be_pkg.sv
// Shared types for the backend control pipe: control fu ops and the staged result payload.
package bp_be_pkg;

  typedef enum logic [3:0] {
    e_ctrl_op_beq  = 4'd0,
    e_ctrl_op_bne  = 4'd1,
    e_ctrl_op_blt  = 4'd2,
    e_ctrl_op_bge  = 4'd3,
    e_ctrl_op_bltu = 4'd4,
    e_ctrl_op_bgeu = 4'd5,
    e_ctrl_op_jal  = 4'd6,
    e_ctrl_op_jalr = 4'd7
  } bp_be_ctrl_fu_op_e;

  // Address fields are sized for the widest supported vaddr; narrower configs zero-fill the top.
  localparam int unsigned bp_max_vaddr_width_gp = 64;

  typedef struct packed {
    logic                             ctl;
    logic                             btaken;
    logic                             mispredict;
    logic                             misaligned;
    logic [bp_max_vaddr_width_gp-1:0] npc;
    logic [bp_max_vaddr_width_gp-1:0] link;
  } bp_be_ctl_pkt_s;

  localparam int unsigned bp_be_ctl_pkt_width_gp = $bits(bp_be_ctl_pkt_s);

endpackage

// File: rtl/bp_be_pipe_ctl_stage.sv
// One pipeline slot of the control pipe: valid bit with async reset and flush kill, plus payload.
module bp_be_pipe_ctl_stage #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               v_i,
  input  logic [width_p-1:0] pkt_i,
  output logic               v_o,
  output logic [width_p-1:0] pkt_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) v_o <= 1'b0;
    else         v_o <= v_i & ~flush_i;
  end

  // Payload is qualified by v_o downstream, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (v_i) pkt_o <= pkt_i;
  end

endmodule

// File: rtl/bp_be_pipe_ctl_mc.sv
// Multi-cycle control pipe: resolves branches/jumps, checks prediction and alignment,
// delivers results after latency_p cycles and keeps saturating branch/mispredict counters.
module bp_be_pipe_ctl_mc
  import bp_be_pkg::*;
#(
  parameter int vaddr_width_p = 39,
  parameter int dword_width_p = 64,
  parameter int latency_p     = 1,
  parameter int compressed_p  = 0,
  parameter int cnt_width_p   = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     v_i,
  input  logic                     ctl_v_i,
  input  logic [3:0]               fu_op_i,
  input  logic                     baddr_sel_i,
  input  logic                     compressed_i,
  input  logic [vaddr_width_p-1:0] pc_i,
  input  logic [dword_width_p-1:0] rs1_i,
  input  logic [dword_width_p-1:0] rs2_i,
  input  logic [dword_width_p-1:0] imm_i,
  input  logic [vaddr_width_p-1:0] pred_npc_i,
  input  logic                     flush_i,
  input  logic                     clr_cnt_i,
  output logic                     v_o,
  output logic [dword_width_p-1:0] data_o,
  output logic                     br_v_o,
  output logic                     branch_o,
  output logic                     btaken_o,
  output logic [vaddr_width_p-1:0] npc_o,
  output logic                     mispredict_o,
  output logic                     misaligned_o,
  output logic [cnt_width_p-1:0]   branch_cnt_o,
  output logic [cnt_width_p-1:0]   mispred_cnt_o
);

  if (latency_p < 1 || latency_p > 3) begin : g_bad_latency
    $error("bp_be_pipe_ctl_mc: latency_p must be in 1..3");
  end
  if (vaddr_width_p > int'(bp_max_vaddr_width_gp) || dword_width_p < vaddr_width_p) begin : g_bad_width
    $error("bp_be_pipe_ctl_mc: need vaddr_width_p <= 64 and dword_width_p >= vaddr_width_p");
  end

  logic                     cond;
  logic                     btaken;
  logic [dword_width_p-1:0] base;
  logic [dword_width_p-1:0] sum;
  logic [vaddr_width_p-1:0] tgt;
  logic [vaddr_width_p-1:0] step;
  logic [vaddr_width_p-1:0] ntgt;
  logic [vaddr_width_p-1:0] npc;
  bp_be_ctl_pkt_s           pkt0;

  always_comb begin
    cond = 1'b0;
    case (fu_op_i)
      e_ctrl_op_beq:  cond = (rs1_i == rs2_i);
      e_ctrl_op_bne:  cond = (rs1_i != rs2_i);
      e_ctrl_op_blt:  cond = ($signed(rs1_i) <  $signed(rs2_i));
      e_ctrl_op_bge:  cond = ($signed(rs1_i) >= $signed(rs2_i));
      e_ctrl_op_bltu: cond = (rs1_i <  rs2_i);
      e_ctrl_op_bgeu: cond = (rs1_i >= rs2_i);
      e_ctrl_op_jal,
      e_ctrl_op_jalr: cond = 1'b1;
      default:        cond = 1'b0;
    endcase
  end

  assign btaken = ctl_v_i & cond;
  assign base   = baddr_sel_i ? rs1_i : dword_width_p'(pc_i);
  assign sum    = base + imm_i;
  assign tgt    = sum[vaddr_width_p-1:0] & ~vaddr_width_p'(1);
  assign step   = ((compressed_p != 0) && compressed_i) ? vaddr_width_p'(2) : vaddr_width_p'(4);
  assign ntgt   = pc_i + step;
  assign npc    = btaken ? tgt : ntgt;

  always_comb begin
    pkt0                          = '0;
    pkt0.ctl                      = ctl_v_i;
    pkt0.btaken                   = btaken;
    pkt0.mispredict               = v_i & ctl_v_i & (npc != pred_npc_i);
    pkt0.misaligned               = btaken & tgt[1] & (compressed_p == 0);
    pkt0.npc[vaddr_width_p-1:0]   = npc;
    pkt0.link[vaddr_width_p-1:0]  = ntgt;
  end

  logic                              stage_v   [latency_p+1];
  logic [bp_be_ctl_pkt_width_gp-1:0] stage_pkt [latency_p+1];

  assign stage_v[0]   = v_i;
  assign stage_pkt[0] = pkt0;

  for (genvar i = 1; i <= latency_p; i++) begin : g_stage
    bp_be_pipe_ctl_stage #(
      .width_p(bp_be_ctl_pkt_width_gp)
    ) stage (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .flush_i(flush_i),
      .v_i    (stage_v[i-1]),
      .pkt_i  (stage_pkt[i-1]),
      .v_o    (stage_v[i]),
      .pkt_o  (stage_pkt[i])
    );
  end

  logic                     out_v;
  bp_be_ctl_pkt_s           out_pkt;
  logic [vaddr_width_p-1:0] link;
  logic                     count;

  assign out_v   = stage_v[latency_p];
  assign out_pkt = stage_pkt[latency_p];
  assign link    = out_pkt.link[vaddr_width_p-1:0];
  assign count   = out_v & out_pkt.ctl;

  assign br_v_o       = out_v;
  assign v_o          = count;
  assign branch_o     = count;
  assign btaken_o     = out_v & out_pkt.btaken;
  assign mispredict_o = out_v & out_pkt.mispredict;
  assign misaligned_o = out_v & out_pkt.misaligned;
  assign npc_o        = out_pkt.npc[vaddr_width_p-1:0];
  assign data_o       = dword_width_p'($signed(link));

  if (dword_width_p > vaddr_width_p) begin : g_sum_hi
    logic unused_sum_hi;
    assign unused_sum_hi = ^sum[dword_width_p-1:vaddr_width_p];
  end
  if (vaddr_width_p < int'(bp_max_vaddr_width_gp)) begin : g_pkt_hi
    logic unused_pkt_hi;
    assign unused_pkt_hi = ^{out_pkt.npc[bp_max_vaddr_width_gp-1:vaddr_width_p],
                             out_pkt.link[bp_max_vaddr_width_gp-1:vaddr_width_p]};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      branch_cnt_o  <= '0;
      mispred_cnt_o <= '0;
    end else if (count) begin
      if (branch_cnt_o != '1)
        branch_cnt_o <= branch_cnt_o + cnt_width_p'(1);
      if (out_pkt.mispredict && (mispred_cnt_o != '1))
        mispred_cnt_o <= mispred_cnt_o + cnt_width_p'(1);
    end
  end

endmodule

// File: tb/tb_bp_be_pipe_ctl_mc.sv
// Directed bench for bp_be_pipe_ctl_mc: two configurations driven from shared inputs.
module tb_bp_be_pipe_ctl_mc;

  localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] NEG4 = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam int unsigned MAX_A = 15;
  localparam int unsigned MAX_B = 32'hFFFF_FFFF;
  localparam int NVEC = 13;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v = 1'b0, ctl_v = 1'b0, baddr_sel = 1'b0, compressed = 1'b0;
  logic        flush = 1'b0, clr = 1'b0;
  logic [3:0]  fu_op = '0;
  logic [38:0] pc = '0, pred = '0;
  logic [63:0] rs1 = '0, rs2 = '0, imm = '0;

  logic        a_v, a_br_v, a_branch, a_btaken, a_misp, a_misal;
  logic [63:0] a_data;
  logic [38:0] a_npc;
  logic [3:0]  a_bcnt, a_mcnt;
  logic        b_v, b_br_v, b_branch, b_btaken, b_misp, b_misal;
  logic [63:0] b_data;
  logic [38:0] b_npc;
  logic [31:0] b_bcnt, b_mcnt;

  int checks = 0;
  int errors = 0;
  int unsigned bc_a = 0, mc_a = 0, bc_b = 0, mc_b = 0;

  always #5 clk = ~clk;

  bp_be_pipe_ctl_mc #(.vaddr_width_p(39), .dword_width_p(64), .latency_p(2),
                      .compressed_p(0), .cnt_width_p(4)) dut_a (
    .clk_i(clk), .reset_i(reset), .v_i(v), .ctl_v_i(ctl_v), .fu_op_i(fu_op),
    .baddr_sel_i(baddr_sel), .compressed_i(compressed), .pc_i(pc), .rs1_i(rs1),
    .rs2_i(rs2), .imm_i(imm), .pred_npc_i(pred), .flush_i(flush), .clr_cnt_i(clr),
    .v_o(a_v), .data_o(a_data), .br_v_o(a_br_v), .branch_o(a_branch),
    .btaken_o(a_btaken), .npc_o(a_npc), .mispredict_o(a_misp), .misaligned_o(a_misal),
    .branch_cnt_o(a_bcnt), .mispred_cnt_o(a_mcnt));

  bp_be_pipe_ctl_mc #(.vaddr_width_p(39), .dword_width_p(64), .latency_p(3),
                      .compressed_p(1), .cnt_width_p(32)) dut_b (
    .clk_i(clk), .reset_i(reset), .v_i(v), .ctl_v_i(ctl_v), .fu_op_i(fu_op),
    .baddr_sel_i(baddr_sel), .compressed_i(compressed), .pc_i(pc), .rs1_i(rs1),
    .rs2_i(rs2), .imm_i(imm), .pred_npc_i(pred), .flush_i(flush), .clr_cnt_i(clr),
    .v_o(b_v), .data_o(b_data), .br_v_o(b_br_v), .branch_o(b_branch),
    .btaken_o(b_btaken), .npc_o(b_npc), .mispredict_o(b_misp), .misaligned_o(b_misal),
    .branch_cnt_o(b_bcnt), .mispred_cnt_o(b_mcnt));

  typedef struct {
    logic [3:0]  op;
    logic        ctl, sel, cmp;
    logic [38:0] pc;
    logic [63:0] rs1, rs2, imm;
    logic [38:0] pred;
    logic        bt;
    logic [38:0] npc_a, npc_b;
    logic [63:0] data_a, data_b;
    logic        misp_a, misp_b, misal_a;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(logic [3:0] op, logic ctl, logic sel, logic cmp,
                              logic [38:0] p, logic [63:0] r1, logic [63:0] r2,
                              logic [63:0] im, logic [38:0] pr, logic bt,
                              logic [38:0] na, logic [38:0] nb, logic [63:0] da,
                              logic [63:0] db, logic ma, logic mb, logic al);
    vec_t x;
    x.op = op; x.ctl = ctl; x.sel = sel; x.cmp = cmp; x.pc = p;
    x.rs1 = r1; x.rs2 = r2; x.imm = im; x.pred = pr; x.bt = bt;
    x.npc_a = na; x.npc_b = nb; x.data_a = da; x.data_b = db;
    x.misp_a = ma; x.misp_b = mb; x.misal_a = al;
    return x;
  endfunction

  function automatic int unsigned sat(int unsigned c, int unsigned mx);
    return (c == mx) ? mx : c + 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t x);
    fu_op = x.op; ctl_v = x.ctl; baddr_sel = x.sel; compressed = x.cmp;
    pc = x.pc; rs1 = x.rs1; rs2 = x.rs2; imm = x.imm; pred = x.pred;
  endtask

  task automatic chk_cnts();
    chk("a_branch_cnt", 64'(a_bcnt), 64'(bc_a));
    chk("a_mispred_cnt", 64'(a_mcnt), 64'(mc_a));
    chk("b_branch_cnt", 64'(b_bcnt), 64'(bc_b));
    chk("b_mispred_cnt", 64'(b_mcnt), 64'(mc_b));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //      op ctl sel cmp pc               rs1     rs2 imm     pred             bt npc_a            npc_b            data_a                 data_b                 ma mb al
    vecs[0]  = mk(0, 1, 0, 0, 39'h1000,     64'd5,  64'd5, 64'h20,  39'h1020,    1, 39'h1020,        39'h1020,        64'h1004,              64'h1004,              0, 0, 0);
    vecs[1]  = mk(2, 1, 0, 0, 39'h2000,     NEG1,   64'd1, 64'h8,   39'h2004,    1, 39'h2008,        39'h2008,        64'h2004,              64'h2004,              1, 1, 0);
    vecs[2]  = mk(7, 1, 1, 0, 39'h5000,     64'h3003, 64'd0, 64'h1, 39'h3004,    1, 39'h3004,        39'h3004,        64'h5004,              64'h5004,              0, 0, 0);
    vecs[3]  = mk(7, 1, 1, 0, 39'h5000,     64'h3001, 64'd0, 64'h1, 39'h3002,    1, 39'h3002,        39'h3002,        64'h5004,              64'h5004,              0, 0, 1);
    vecs[4]  = mk(1, 1, 0, 1, 39'h400,      64'd7,  64'd7, 64'h40,  39'h402,     0, 39'h404,         39'h402,         64'h404,               64'h402,               1, 0, 0);
    vecs[5]  = mk(4, 1, 0, 0, 39'h600,      NEG1,   64'd1, 64'h10,  39'h604,     0, 39'h604,         39'h604,         64'h604,               64'h604,               0, 0, 0);
    vecs[6]  = mk(3, 1, 0, 0, 39'h700,      NEG1,   64'd1, 64'h10,  39'h710,     0, 39'h704,         39'h704,         64'h704,               64'h704,               1, 1, 0);
    vecs[7]  = mk(5, 1, 0, 0, 39'h800,      NEG1,   64'd1, 64'h10,  39'h810,     1, 39'h810,         39'h810,         64'h804,               64'h804,               0, 0, 0);
    vecs[8]  = mk(6, 1, 0, 0, 39'h900,      64'd0,  64'd0, NEG4,    39'h0,       1, 39'h8FC,         39'h8FC,         64'h904,               64'h904,               1, 1, 0);
    vecs[9]  = mk(8, 1, 0, 0, 39'hA00,      64'd1,  64'd1, 64'h40,  39'hA04,     0, 39'hA04,         39'hA04,         64'hA04,               64'hA04,               0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 39'hB00,      64'd9,  64'd9, 64'h100, 39'h0,       0, 39'hB04,         39'hB04,         64'hB04,               64'hB04,               0, 0, 0);
    vecs[11] = mk(0, 1, 0, 0, 39'h7F_FFFF_FFFC, 64'd1, 64'd2, 64'h0, 39'h0,      0, 39'h0,           39'h0,           64'h0,                 64'h0,                 0, 0, 0);
    vecs[12] = mk(1, 1, 0, 0, 39'h40_0000_0000, 64'd3, 64'd3, 64'h8, 39'h40_0000_0004, 0, 39'h40_0000_0004, 39'h40_0000_0004, 64'hFFFF_FFC0_0000_0004, 64'hFFFF_FFC0_0000_0004, 0, 0, 0);

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_a_br_v", 64'(a_br_v), 64'd0);
    chk("rst_b_br_v", 64'(b_br_v), 64'd0);
    chk("rst_a_v", 64'(a_v), 64'd0);
    chk("rst_b_v", 64'(b_v), 64'd0);
    chk_cnts();
    reset = 1'b0;

    // Table: one op at a time; A emerges 2 edges after capture, B 3 edges after capture
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk); drive(vecs[i]); v = 1'b1;
      @(negedge clk); v = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_a_br_v", i), 64'(a_br_v), 64'd1);
      chk($sformatf("v%0d_a_v", i), 64'(a_v), 64'(vecs[i].ctl));
      chk($sformatf("v%0d_a_branch", i), 64'(a_branch), 64'(vecs[i].ctl));
      chk($sformatf("v%0d_a_btaken", i), 64'(a_btaken), 64'(vecs[i].bt));
      chk($sformatf("v%0d_a_npc", i), 64'(a_npc), 64'(vecs[i].npc_a));
      chk($sformatf("v%0d_a_data", i), a_data, vecs[i].data_a);
      chk($sformatf("v%0d_a_misp", i), 64'(a_misp), 64'(vecs[i].misp_a));
      chk($sformatf("v%0d_a_misal", i), 64'(a_misal), 64'(vecs[i].misal_a));
      @(negedge clk);
      chk($sformatf("v%0d_a_br_v_gone", i), 64'(a_br_v), 64'd0);
      chk($sformatf("v%0d_b_br_v", i), 64'(b_br_v), 64'd1);
      chk($sformatf("v%0d_b_v", i), 64'(b_v), 64'(vecs[i].ctl));
      chk($sformatf("v%0d_b_btaken", i), 64'(b_btaken), 64'(vecs[i].bt));
      chk($sformatf("v%0d_b_npc", i), 64'(b_npc), 64'(vecs[i].npc_b));
      chk($sformatf("v%0d_b_data", i), b_data, vecs[i].data_b);
      chk($sformatf("v%0d_b_misp", i), 64'(b_misp), 64'(vecs[i].misp_b));
      chk($sformatf("v%0d_b_misal", i), 64'(b_misal), 64'd0);
      @(negedge clk);
      if (vecs[i].ctl) begin
        bc_a = sat(bc_a, MAX_A); bc_b = sat(bc_b, MAX_B);
        if (vecs[i].misp_a) mc_a = sat(mc_a, MAX_A);
        if (vecs[i].misp_b) mc_b = sat(mc_b, MAX_B);
      end
      chk_cnts();
    end

    // Flush on the 3rd of three back-to-back issues; first op is non-ctl
    @(negedge clk); drive(vecs[0]); ctl_v = 1'b0; v = 1'b1;
    @(negedge clk); ctl_v = 1'b1;
    @(negedge clk); flush = 1'b1;
    chk("fl_a_first_out", 64'(a_br_v), 64'd1);
    chk("fl_a_first_nonctl", 64'(a_v), 64'd0);
    @(negedge clk); v = 1'b0; flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fl_a_br_v_%0d", k), 64'(a_br_v), 64'd0);
      chk($sformatf("fl_b_br_v_%0d", k), 64'(b_br_v), 64'd0);
      @(negedge clk);
    end
    chk_cnts();

    // Saturation: 16 back-to-back mispredicted ops
    @(negedge clk); drive(vecs[0]); pred = 39'h0; v = 1'b1;
    repeat (16) @(negedge clk);
    v = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      bc_a = sat(bc_a, MAX_A); mc_a = sat(mc_a, MAX_A);
      bc_b = sat(bc_b, MAX_B); mc_b = sat(mc_b, MAX_B);
    end
    chk("sat_a_branch_cnt", 64'(a_bcnt), 64'hF);
    chk("sat_a_mispred_cnt", 64'(a_mcnt), 64'hF);
    chk_cnts();

    // Clear coinciding with a valid op at A's output stage
    @(negedge clk); drive(vecs[0]); v = 1'b1;
    @(negedge clk); v = 1'b0;
    @(negedge clk); clr = 1'b1;
    chk("clr_a_v", 64'(a_v), 64'd1);
    @(negedge clk); clr = 1'b0;
    bc_a = 0; mc_a = 0; bc_b = 0; mc_b = 0;
    chk_cnts();
    @(negedge clk);
    bc_b = 1;
    chk_cnts();

    // Asynchronous reset mid-stream
    @(negedge clk); drive(vecs[1]); v = 1'b1;
    repeat (3) @(negedge clk);
    chk("prerst_a_br_v", 64'(a_br_v), 64'd1);
    chk("prerst_b_br_v", 64'(b_br_v), 64'd1);
    chk("prerst_a_bcnt", 64'(a_bcnt), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_a_br_v", 64'(a_br_v), 64'd0);
    chk("arst_b_br_v", 64'(b_br_v), 64'd0);
    chk("arst_a_v", 64'(a_v), 64'd0);
    chk("arst_b_v", 64'(b_v), 64'd0);
    chk("arst_a_btaken", 64'(a_btaken), 64'd0);
    chk("arst_a_misp", 64'(a_misp), 64'd0);
    chk("arst_b_misp", 64'(b_misp), 64'd0);
    bc_a = 0; mc_a = 0; bc_b = 0; mc_b = 0;
    chk_cnts();
    v = 1'b0;
    @(negedge clk); reset = 1'b0;

    // Resume after reset
    drive(vecs[0]); v = 1'b1;
    @(negedge clk); v = 1'b0;
    @(negedge clk);
    chk("res_a_br_v", 64'(a_br_v), 64'd1);
    chk("res_a_npc", 64'(a_npc), 64'h1020);
    @(negedge clk);
    chk("res_b_br_v", 64'(b_br_v), 64'd1);
    chk("res_b_data", b_data, 64'h1004);
    @(negedge clk);
    bc_a = 1; bc_b = 1;
    chk_cnts();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
